fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sits between the PC register and instruction memory.
- Consumes the current PC (pc_i) and issues one instruction-memory request at a time using a req/gnt/rvalid protocol.
- Buffers the returned word and presents it to decode with a valid/ready handshake.
- Generates PC_Next for the PC register, which loads every clock: hold, +4 on handoff, or redirect target. Stalls are therefore expressed by feeding back pc_i.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- PC_STEP, 4, increment applied to PC on each handoff.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low (rst==0 resets on posedge clk).
- pc_i  input  XLEN  current PC from the PC register.
- pc_next_o  output  XLEN  next PC, driven to the PC register's PC_Next.
- redirect_i  input  1  branch/jump taken this cycle.
- redirect_target_i  input  XLEN  redirect destination.
- imem_req_o  output  1  memory request valid.
- imem_addr_o  output  XLEN  request address; equals pc_i.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid.
- imem_rdata_i  input  XLEN  response instruction word.
- instr_valid_o  output  1  buffered instruction valid.
- instr_o  output  XLEN  buffered instruction.
- instr_pc_o  output  XLEN  PC of the buffered instruction.
- instr_ready_i  input  1  decode accepts instruction.
- fetch_err_o  output  1  sticky misaligned-PC flag.
- instr_count_o  output  32  number of instructions handed off (wraps).

Behaviour:
- States: IDLE, WAIT, HOLD, DRAIN, ERR. At most one request outstanding.
- Reset (rst==0 at posedge): state=IDLE.
  - All registered outputs clear: instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_err_o=0, instr_count_o=0.
  - A response arriving after reset finds IDLE and is ignored.
- pc_next_o is combinational, in priority order:
  - redirect_i=1 -> redirect_target_i.
  - else handoff (instr_valid_o & instr_ready_i) -> pc_i+PC_STEP, mod 2^XLEN (wraps 0xFFFFFFFC -> 0).
  - else -> pc_i.
- imem_req_o=1 only in IDLE with redirect_i=0 and pc_i[1:0]==0. While imem_req_o=1, imem_addr_o=pc_i.
- IDLE transitions:
  - req & gnt -> WAIT.
  - req & !gnt -> stay IDLE; the request is held until granted.
  - pc_i[1:0]!=0 and no redirect -> ERR, fetch_err_o=1 next cycle.
  - rvalid in IDLE is ignored.
- WAIT transitions:
  - rvalid & !redirect -> HOLD. Latch instr_o=imem_rdata_i and instr_pc_o=pc_i; instr_valid_o=1 from the next cycle.
  - redirect & rvalid same cycle -> data discarded, go IDLE.
  - redirect & !rvalid -> DRAIN.
- HOLD transitions:
  - instr_valid_o=1 and instr_o/instr_pc_o stable until handoff.
  - handoff & !redirect -> IDLE, instr_valid_o=0, instr_count_o+1.
  - redirect (with or without ready) -> IDLE, instr_valid_o=0, no count, pc_next_o=target.
- DRAIN transitions:
  - Wait for the orphaned response; rvalid -> IDLE, data dropped.
  - Further redirects in DRAIN only update pc_next_o; state stays DRAIN.
- ERR transitions:
  - No requests are issued.
  - redirect_i -> IDLE and fetch_err_o clears the next cycle.
- Latency: minimum 3 cycles per instruction (IDLE grant, WAIT rvalid, HOLD handoff) with zero-wait memory and ready decode.
- instr_valid_o never asserts in IDLE, WAIT, DRAIN or ERR.

Test Plan:
- Reset, then zero-wait memory (gnt same cycle, rvalid next cycle), ready=1, pc starts 0x0:
  - required: handoffs with instr_pc_o = 0x0, 0x4, 0x8, one every 3 cycles; instr_count_o=3 after the third.
- Backpressure: hold instr_ready_i=0 for 5 cycles in HOLD:
  - required: instr_valid_o stays 1, instr_o/instr_pc_o unchanged, pc_next_o=pc_i, no imem_req_o.
  - On ready=1: pc_next_o=pc_i+4.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later:
  - required: state DRAIN, response word not presented.
  - Next request has imem_addr_o=0x100; instr_count_o unchanged.
- Redirect to 0x200 in the same cycle as the HOLD handoff:
  - required: instr_valid_o=0 next cycle, instr_count_o not incremented, pc_next_o=0x200.
- Redirect to 0x102:
  - required: no imem_req_o, fetch_err_o=1 the cycle after ERR entry.
  - Later redirect to 0x300: fetch_err_o=0 and imem_addr_o=0x300.
- Assert rst=0 mid-WAIT, release, then rvalid arrives:
  - required: rvalid ignored, all outputs at reset values, a fresh request issued from pc_i.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one instruction-memory request at a time,
// buffers the returned word for decode and generates PC_Next for the PC register.
module fetch_sequencer #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fetch_err_o,
  output logic [31:0]     instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t          r_state;
  logic            r_instr_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_fetch_err;
  logic [31:0]     r_instr_count;

  logic w_misaligned;
  logic w_req;
  logic w_handoff;

  assign w_misaligned = (pc_i[1:0] != 2'b00);
  assign w_req        = (r_state == S_IDLE) && !redirect_i && !w_misaligned;
  assign w_handoff    = r_instr_valid && instr_ready_i;

  // The PC register loads every cycle, so "stall" means feeding pc_i back.
  always_comb begin
    if (redirect_i)     pc_next_o = redirect_target_i;
    else if (w_handoff) pc_next_o = pc_i + XLEN'(PC_STEP);
    else                pc_next_o = pc_i;
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = pc_i;
  assign instr_valid_o = r_instr_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign fetch_err_o   = r_fetch_err;
  assign instr_count_o = r_instr_count;

  // NOTE: all state below is sequential, so every assignment is non-blocking;
  // the data registers are reset too because their reset values are visible outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fetch_err   <= 1'b0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!redirect_i) begin
            if (w_misaligned) begin
              r_state     <= S_ERR;
              r_fetch_err <= 1'b1;
            end else if (imem_gnt_i) begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect_i) begin
              r_state <= S_IDLE;
            end else begin
              r_state       <= S_HOLD;
              r_instr       <= imem_rdata_i;
              r_instr_pc    <= pc_i;
              r_instr_valid <= 1'b1;
            end
          end else if (redirect_i) begin
            // The response is still owed; it must be swallowed before refetching.
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            r_state       <= S_IDLE;
            r_instr_valid <= 1'b0;
          end else if (instr_ready_i) begin
            r_state       <= S_IDLE;
            r_instr_valid <= 1'b0;
            r_instr_count <= r_instr_count + 32'd1;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) r_state <= S_IDLE;
        end
        S_ERR: begin
          if (redirect_i) begin
            r_state     <= S_IDLE;
            r_fetch_err <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] pc_next_o;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        fetch_err_o;
  logic [31:0] instr_count_o;

  fetch_sequencer #(.XLEN(32), .PC_STEP(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc_i),
    .pc_next_o         (pc_next_o),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_ready_i     (instr_ready_i),
    .fetch_err_o       (fetch_err_o),
    .instr_count_o     (instr_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: loads PC_Next every clock.
  always @(posedge clk) pc_i <= pc_next_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: what the fetcher owes, holds or is blocked on.
  logic        m_known   = 1'b0;
  logic        m_pending = 1'b0;
  logic        m_drop    = 1'b0;
  logic        m_buf     = 1'b0;
  logic        m_err     = 1'b0;
  logic [31:0] m_word    = '0;
  logic [31:0] m_bpc     = '0;
  logic [31:0] m_count   = '0;

  // Zero-wait memory responder used by the directed steps.
  logic        auto_mem  = 1'b0;
  logic        owe       = 1'b0;
  logic [31:0] owe_addr  = '0;

  int hand_pc[$];
  int hand_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        idle;
    logic [31:0] pc_s, tgt_s, rdata_s, exp_next;
    logic        rst_s, redir_s, gnt_s, rv_s, rdy_s, granted;
    #1;
    pc_s = pc_i;       rst_s = rst;          redir_s = redirect_i;
    tgt_s = redirect_target_i;               gnt_s = imem_gnt_i;
    rv_s = imem_rvalid_i; rdata_s = imem_rdata_i; rdy_s = instr_ready_i;
    if (m_known) begin
      idle = !m_pending && !m_buf && !m_err;
      check("req", 32'(imem_req_o), 32'(idle && !redir_s && (pc_s[1:0] == 2'b00)));
      check("addr", imem_addr_o, pc_s);
      if (redir_s)             exp_next = tgt_s;
      else if (m_buf && rdy_s) exp_next = pc_s + 32'd4;
      else                     exp_next = pc_s;
      check("pc_next", pc_next_o, exp_next);
    end
    if (instr_valid_o === 1'b1 && rdy_s && !redir_s) begin
      hand_pc.push_back(int'(instr_pc_o));
      hand_cyc.push_back(cyc);
    end
    granted = (imem_req_o === 1'b1) && gnt_s;

    @(posedge clk);
    idle = !m_pending && !m_buf && !m_err;
    if (!rst_s) begin
      m_known = 1'b1; m_pending = 1'b0; m_drop = 1'b0; m_buf = 1'b0; m_err = 1'b0;
      m_word = '0; m_bpc = '0; m_count = '0;
    end else if (idle) begin
      if (!redir_s) begin
        if (pc_s[1:0] != 2'b00) m_err = 1'b1;
        else if (gnt_s)         m_pending = 1'b1;
      end
    end else if (m_pending) begin
      if (m_drop) begin
        if (rv_s) begin m_pending = 1'b0; m_drop = 1'b0; end
      end else if (rv_s) begin
        m_pending = 1'b0;
        if (!redir_s) begin m_buf = 1'b1; m_word = rdata_s; m_bpc = pc_s; end
      end else if (redir_s) begin
        m_drop = 1'b1;
      end
    end else if (m_buf) begin
      if (redir_s)    m_buf = 1'b0;
      else if (rdy_s) begin m_buf = 1'b0; m_count = m_count + 32'd1; end
    end else if (m_err) begin
      if (redir_s) m_err = 1'b0;
    end

    #1;
    if (m_known) begin
      check("instr_valid", 32'(instr_valid_o), 32'(m_buf));
      check("instr", instr_o, m_word);
      check("instr_pc", instr_pc_o, m_bpc);
      check("fetch_err", 32'(fetch_err_o), 32'(m_err));
      check("instr_count", instr_count_o, m_count);
    end
    cyc++;
    owe = granted;
    if (granted) owe_addr = pc_s;
    if (auto_mem) begin
      imem_gnt_i    = 1'b1;
      imem_rvalid_i = owe;
      imem_rdata_i  = owe_addr ^ 32'hA5A5_0000;
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (instr_valid_o !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("wait_valid_timeout", 32'(instr_valid_o === 1'b1), 32'd1);
  endtask

  initial begin
    int r;
    rst = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_instr_pc", instr_pc_o, 32'd0);
    check("rst_err", 32'(fetch_err_o), 32'd0);
    check("rst_count", instr_count_o, 32'd0);

    // Zero-wait memory, ready decode: one handoff every 3 cycles.
    rst = 1'b1; instr_ready_i = 1'b1; auto_mem = 1'b1; imem_gnt_i = 1'b1;
    hand_pc.delete(); hand_cyc.delete();
    for (int i = 0; i < 9; i++) tick();
    check("stream_n", 32'(hand_pc.size()), 32'd3);
    if (hand_pc.size() == 3) begin
      check("stream_pc0", 32'(hand_pc[0]), 32'h0);
      check("stream_pc1", 32'(hand_pc[1]), 32'h4);
      check("stream_pc2", 32'(hand_pc[2]), 32'h8);
      check("stream_gap1", 32'(hand_cyc[1] - hand_cyc[0]), 32'd3);
      check("stream_gap2", 32'(hand_cyc[2] - hand_cyc[1]), 32'd3);
    end
    check("stream_count", instr_count_o, 32'd3);

    // Backpressure in HOLD.
    instr_ready_i = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(instr_valid_o), 32'd1);
      check("bp_instr", instr_o, 32'hA5A5_000C);
      check("bp_instr_pc", instr_pc_o, 32'hC);
      check("bp_pc_next", pc_next_o, 32'hC);
      check("bp_req", 32'(imem_req_o), 32'd0);
      tick();
    end
    instr_ready_i = 1'b1;
    #1;
    check("bp_release_pc_next", pc_next_o, 32'h10);
    tick();
    check("bp_count", instr_count_o, 32'd4);

    // Redirect while WAIT; orphaned response arrives two cycles later.
    auto_mem = 1'b0; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
    tick();
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_target_i = 32'h100;
    #1;
    check("wait_redir_pc_next", pc_next_o, 32'h100);
    tick();
    redirect_i = 1'b0;
    #1;
    check("drain_req0", 32'(imem_req_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("drain_req1", 32'(imem_req_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("drain_valid", 32'(instr_valid_o), 32'd0);
    check("drain_instr_kept", instr_o, 32'hA5A5_000C);
    check("drain_next_req", 32'(imem_req_o), 32'd1);
    check("drain_next_addr", imem_addr_o, 32'h100);
    check("drain_count", instr_count_o, 32'd4);

    // Redirect coincident with handoff.
    auto_mem = 1'b1; imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
    wait_valid(10);
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h200;
    #1;
    check("hold_redir_pc_next", pc_next_o, 32'h200);
    tick();
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    check("hold_redir_valid", 32'(instr_valid_o), 32'd0);
    check("hold_redir_count", instr_count_o, 32'd4);
    check("hold_redir_pc", pc_i, 32'h200);

    // Misaligned target -> ERR, then recover.
    redirect_i = 1'b1; redirect_target_i = 32'h102;
    #1;
    check("redir_idle_req", 32'(imem_req_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    check("misaligned_req", 32'(imem_req_o), 32'd0);
    tick();
    check("err_set", 32'(fetch_err_o), 32'd1);
    tick();
    check("err_hold", 32'(fetch_err_o), 32'd1);
    check("err_no_req", 32'(imem_req_o), 32'd0);
    redirect_i = 1'b1; redirect_target_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    #1;
    check("err_clear", 32'(fetch_err_o), 32'd0);
    check("err_recover_req", 32'(imem_req_o), 32'd1);
    check("err_recover_addr", imem_addr_o, 32'h300);

    // Reset mid-WAIT, then the stale response arrives.
    auto_mem = 1'b0; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
    tick();
    rst = 1'b0; imem_gnt_i = 1'b0;
    tick();
    rst = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("rst_wait_valid", 32'(instr_valid_o), 32'd0);
    check("rst_wait_instr", instr_o, 32'd0);
    check("rst_wait_instr_pc", instr_pc_o, 32'd0);
    check("rst_wait_count", instr_count_o, 32'd0);
    check("rst_wait_err", 32'(fetch_err_o), 32'd0);
    check("rst_wait_req", 32'(imem_req_o), 32'd1);
    check("rst_wait_addr", imem_addr_o, 32'h300);

    // PC wrap on handoff.
    redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0; auto_mem = 1'b1; imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
    wait_valid(10);
    instr_ready_i = 1'b1;
    #1;
    check("wrap_instr_pc", instr_pc_o, 32'hFFFF_FFFC);
    check("wrap_pc_next", pc_next_o, 32'h0);
    tick();
    check("wrap_pc", pc_i, 32'h0);

    // Random traffic against the model.
    auto_mem = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) != 0);
      imem_gnt_i    = $urandom_range(0, 1) == 1;
      imem_rvalid_i = $urandom_range(0, 9) < 4;
      imem_rdata_i  = $urandom;
      instr_ready_i = $urandom_range(0, 9) < 7;
      redirect_i    = $urandom_range(0, 99) < 8;
      r = $urandom_range(0, 15);
      if (r == 0)      redirect_target_i = 32'hFFFF_FFFC;
      else if (r == 1) redirect_target_i = {$urandom_range(0, 65535), 14'h0, 2'($urandom_range(1, 3))};
      else             redirect_target_i = $urandom & 32'hFFFF_FFFC;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
